// File: rtl/jtframe_sdram_rrarb_pkg.sv
// jtframe_sdram_rrarb_pkg: shared SDRAM arbiter state encodings, default watchdog limit and sizing helper
package jtframe_sdram_rrarb_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } arb_state_t;
    localparam int TOUT_DEF = 255;
    function automatic int wd_width(input int tout);
        return ($clog2(tout + 1) > 8) ? $clog2(tout + 1) : 8;
    endfunction
endpackage

// File: rtl/jtframe_sdram_rrarb_pick.sv
// jtframe_rr_pick: round-robin picker, first set request searching upward from last+1 (mod N)
module jtframe_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  hit,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] c;
    always_comb begin
        any = 1'b0;
        idx = '0;
        c   = '0;
        for (int k = 1; k <= N; k++) begin
            c = IW'((int'(last) + k) % N);
            if (!any && req[c]) begin
                any = 1'b1;
                idx = c;
            end
        end
    end
    assign hit = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/jtframe_sdram_rrarb.sv
// jtframe_sdram_rrarb: round-robin arbiter of N requesters onto one SDRAM controller port,
// with zero-gap back-to-back service and a watchdog that abandons stuck transactions.
module jtframe_sdram_rrarb
    import jtframe_sdram_rrarb_pkg::*;
#(
    parameter int SDRAMW = 22,
    parameter int N      = 4,
    parameter int TOUT   = TOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        rnw,
    input  logic [N*SDRAMW-1:0] addr,
    input  logic [N*16-1:0]     din,
    input  logic [N*2-1:0]      wrmask,
    output logic [N-1:0]        sel,
    output logic                sdram_rd,
    output logic                sdram_wr,
    output logic [SDRAMW-1:0]   sdram_addr,
    output logic [15:0]         data_write,
    output logic [1:0]          sdram_wrmask,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    output logic                busy,
    output logic                tout_err
);
    localparam int IW = $clog2(N);
    localparam int WW = wd_width(TOUT);

    arb_state_t        st;
    logic [IW-1:0]     last, idx;
    logic [N-1:0]      hit;
    logic              any, cplt, grant, expire;
    logic [WW-1:0]     wd;
    logic [SDRAMW-1:0] w_addr;
    logic [15:0]       w_din;
    logic [1:0]        w_mask;
    logic              w_rnw;

    jtframe_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req  (req & ~sel),
        .last (last),
        .hit  (hit),
        .idx  (idx),
        .any  (any)
    );

    always_comb begin
        w_addr = '0;
        w_din  = '0;
        w_mask = 2'b11;
        w_rnw  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                w_addr = addr[i*SDRAMW +: SDRAMW];
                w_din  = din[i*16 +: 16];
                w_mask = wrmask[i*2 +: 2];
                w_rnw  = rnw[i];
            end
        end
    end

    // ack and data_rdy together in WAIT_ACK count as completion
    assign cplt   = data_rdy && (st == WAIT_DATA || (st == WAIT_ACK && sdram_ack));
    assign grant  = (st == IDLE || cplt) && any;
    assign expire = busy && wd == WW'(TOUT - 1);
    assign busy   = st != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= IDLE;
            sel          <= '0;
            sdram_rd     <= 1'b0;
            sdram_wr     <= 1'b0;
            sdram_addr   <= '0;
            data_write   <= '0;
            sdram_wrmask <= 2'b11;
            last         <= IW'(N - 1);
            wd           <= '0;
            tout_err     <= 1'b0;
        end else begin
            tout_err <= 1'b0;
            wd       <= grant ? '0 : busy ? wd + 1'b1 : wd;
            if (grant) begin
                st           <= WAIT_ACK;
                sel          <= hit;
                sdram_addr   <= w_addr;
                data_write   <= w_din;
                sdram_wrmask <= w_rnw ? 2'b11 : w_mask;
                sdram_rd     <= w_rnw;
                sdram_wr     <= ~w_rnw;
                last         <= idx;
            end else if (cplt || expire) begin
                st       <= IDLE;
                sel      <= '0;
                sdram_rd <= 1'b0;
                sdram_wr <= 1'b0;
                tout_err <= !cplt;
            end else if (st == WAIT_ACK && sdram_ack) begin
                st       <= WAIT_DATA;
                sdram_rd <= 1'b0;
                sdram_wr <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jtframe_sdram_rrarb.sv
// tb_jtframe_sdram_rrarb: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_jtframe_sdram_rrarb;
    localparam int N  = 4;
    localparam int AW = 22;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, rnw, sel;
    logic [N*AW-1:0] addr;
    logic [N*16-1:0] din;
    logic [N*2-1:0]  wrmask;
    logic            sdram_rd, sdram_wr, sdram_ack, data_rdy, busy, tout_err;
    logic [AW-1:0]   sdram_addr;
    logic [15:0]     data_write;
    logic [1:0]      sdram_wrmask;

    jtframe_sdram_rrarb #(.SDRAMW(AW), .N(N), .TOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .rnw          (rnw),
        .addr         (addr),
        .din          (din),
        .wrmask       (wrmask),
        .sel          (sel),
        .sdram_rd     (sdram_rd),
        .sdram_wr     (sdram_wr),
        .sdram_addr   (sdram_addr),
        .data_write   (data_write),
        .sdram_wrmask (sdram_wrmask),
        .sdram_ack    (sdram_ack),
        .data_rdy     (data_rdy),
        .busy         (busy),
        .tout_err     (tout_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    // model: owner of the port (-1 none), phase 0 idle / 1 command pending / 2 awaiting data
    int m_own, m_ph, m_last, m_gcyc, cyc = 0;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_dw;
    logic [1:0]    m_mask;
    logic          m_rnw, m_terr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] elig;
        logic done;
        int win;
        if (rst) begin
            m_own = -1; m_ph = 0; m_last = N - 1; m_addr = '0; m_dw = '0;
            m_mask = 2'b11; m_rnw = 1'b1; m_terr = 1'b0;
        end else begin
            elig = req;
            if (m_own >= 0) elig[m_own] = 1'b0;
            done = data_rdy && (m_ph == 2 || (m_ph == 1 && sdram_ack));
            win = -1;
            for (int k = 1; k <= N; k++)
                if (win < 0 && elig[(m_last + k) % N]) win = (m_last + k) % N;
            m_terr = 1'b0;
            if ((m_ph == 0 || done) && win >= 0) begin
                m_own = win; m_ph = 1; m_last = win; m_gcyc = cyc;
                m_addr = addr[win*AW +: AW];
                m_dw   = din[win*16 +: 16];
                m_rnw  = rnw[win];
                m_mask = rnw[win] ? 2'b11 : wrmask[win*2 +: 2];
            end else if (done) begin
                m_own = -1; m_ph = 0;
            end else if (m_ph != 0 && cyc - m_gcyc == TO) begin
                m_own = -1; m_ph = 0; m_terr = 1'b1;
            end else if (m_ph == 1 && sdram_ack) begin
                m_ph = 2;
            end
        end
        cyc++;
    endtask

    task automatic step();
        logic [N-1:0] es;
        model_edge();
        @(negedge clk);
        es = '0;
        if (m_own >= 0) es[m_own] = 1'b1;
        chk("sel", sel, es);
        chk("rd", sdram_rd, m_ph == 1 && m_rnw);
        chk("wr", sdram_wr, m_ph == 1 && !m_rnw);
        chk("addr", sdram_addr, m_addr);
        chk("data", data_write, m_dw);
        chk("mask", sdram_wrmask, m_mask);
        chk("busy", busy, m_ph != 0);
        chk("tout", tout_err, m_terr);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic a, input logic d);
        req = r; sdram_ack = a; data_rdy = d;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; sdram_ack = 1'b0; data_rdy = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        rnw = '1; addr = '0; din = '0; wrmask = '1;
        @(negedge clk);
        do_reset();
        chk("reset_mask", sdram_wrmask, 2'b11);
        chk("reset_sel", sel, 4'b0000);

        // single read on requester 0
        addr[0 +: AW] = 22'h12345;
        drive(4'b0001, 0, 0);
        chk("rd_sel", sel, 4'b0001);
        chk("rd_addr", sdram_addr, 22'h12345);
        drive(4'b0000, 0, 0);
        drive(4'b0000, 1, 0);
        chk("rd_strobe_cleared", sdram_rd, 1'b0);
        repeat (2) drive(4'b0000, 0, 0);
        drive(4'b0000, 0, 1);
        chk("rd_idle", busy, 1'b0);

        // all requesters held: strict rotation, no gaps
        do_reset();
        rnw = 4'b1010;
        drive(4'b1111, 0, 0);
        for (int t = 0; t < 8; t++) begin
            chk("rr_order", sel, 4'b0001 << (t % 4));
            chk("rr_strobe", sdram_rd | sdram_wr, 1'b1);
            drive(4'b1111, 1, 0);
            drive(4'b1111, 0, 0);
            drive(4'b1111, 0, 1);
        end
        drive(4'b0000, 1, 0);
        drive(4'b0000, 0, 1);

        // masked write on requester 2
        do_reset();
        rnw = 4'b1011; din[2*16 +: 16] = 16'hBEEF; wrmask[2*2 +: 2] = 2'b01;
        drive(4'b0100, 0, 0);
        chk("wr_strobe", sdram_wr, 1'b1);
        chk("wr_rd", sdram_rd, 1'b0);
        chk("wr_data", data_write, 16'hBEEF);
        chk("wr_mask", sdram_wrmask, 2'b01);
        drive(4'b0000, 1, 0);
        drive(4'b0000, 0, 1);

        // ack and data_rdy together with requester 1 waiting
        rnw = '1;
        drive(4'b0001, 0, 0);
        drive(4'b0011, 1, 1);
        chk("ackrdy_sel", sel, 4'b0010);
        chk("ackrdy_rd", sdram_rd, 1'b1);
        drive(4'b0000, 1, 0);
        drive(4'b0000, 0, 1);

        // watchdog
        do_reset();
        drive(4'b0011, 0, 0);
        pulses = 0;
        for (int t = 1; t <= TO; t++) begin
            drive(4'b0010, 0, 0);
            if (tout_err) pulses++;
            if (t == TO) chk("tout_at_limit", tout_err, 1'b1);
        end
        chk("tout_pulses", pulses, 1);
        chk("tout_sel", sel, 4'b0000);
        drive(4'b0010, 0, 0);
        chk("tout_next", sel, 4'b0010);
        drive(4'b0000, 1, 0);
        drive(4'b0000, 0, 1);

        // reset in WAIT_DATA, then stray data_rdy
        drive(4'b0001, 0, 0);
        drive(4'b0000, 1, 0);
        rst = 1'b1;
        drive(4'b0000, 0, 0);
        rst = 1'b0;
        drive(4'b0000, 0, 1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sel", sel, 4'b0000);
        chk("rst_tout", tout_err, 1'b0);

        // randomized traffic, with silent windows that let the watchdog fire
        for (int i = 0; i < 4000; i++) begin
            bit silent;
            silent = (i / 150) % 4 == 3;
            rst = $urandom_range(0, 199) == 0;
            rnw = N'($urandom);
            for (int r = 0; r < N; r++) begin
                addr[r*AW +: AW] = AW'($urandom);
                din[r*16 +: 16]  = 16'($urandom);
                wrmask[r*2 +: 2] = 2'($urandom);
            end
            drive(N'($urandom) & N'($urandom),
                  !silent && $urandom_range(0, 2) == 0,
                  !silent && $urandom_range(0, 3) == 0);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
